// File: rtl/stopwatch_display.sv
// BCD MM:SS stopwatch driven by divider levels, with pause, per-field adjust
// and a 4-digit multiplexed active-low seven-segment display.
module stopwatch_display (
  input  logic       clk,
  input  logic       rst,
  input  logic       onehz_clk,
  input  logic       twohz_clk,
  input  logic       fast_clk,
  input  logic       blink_clk,
  input  logic       pause_btn,
  input  logic       adj,
  input  logic       sel,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       paused,
  output logic [3:0] an,
  output logic [7:0] seg
);

  logic [3:0] lvl;
  logic [3:0] prev_reg;
  logic [3:0] tick;
  logic       armed_reg;
  logic [1:0] digit_idx_reg;

  logic       count_en;
  logic       adj_en;
  logic       sec_wrap;
  logic       sec_inc;
  logic       min_inc;

  logic [3:0] digit_val;
  logic [3:0] an_next;
  logic [7:0] seg_next;
  logic       blank;

  // Bit order: 0 = 1 Hz, 1 = 2 Hz, 2 = scan, 3 = pause button.
  // armed_reg masks the first cycle after reset so a level already high at
  // release is absorbed into prev_reg instead of producing a tick.
  assign lvl  = {pause_btn, fast_clk, twohz_clk, onehz_clk};
  assign tick = lvl & ~prev_reg & {4{armed_reg}};

  assign count_en = tick[0] & ~adj & ~paused;
  assign adj_en   = tick[1] & adj & ~paused;
  assign sec_wrap = (sec_tens == 3'd5) && (sec_ones == 4'd9);
  assign sec_inc  = count_en | (adj_en & sel);
  assign min_inc  = (count_en & sec_wrap) | (adj_en & ~sel);

  always_comb begin
    digit_val = sec_ones;
    an_next   = 4'b1110;
    case (digit_idx_reg)
      2'd0: begin digit_val = sec_ones;           an_next = 4'b1110; end
      2'd1: begin digit_val = {1'b0, sec_tens};   an_next = 4'b1101; end
      2'd2: begin digit_val = min_ones;           an_next = 4'b1011; end
      2'd3: begin digit_val = {1'b0, min_tens};   an_next = 4'b0111; end
    endcase
    // Digits 0-1 are the seconds field, digits 2-3 the minutes field.
    blank = adj & blink_clk & (sel ? ~digit_idx_reg[1] : digit_idx_reg[1]);
    if (blank) an_next = 4'b1111;
    case (digit_val)
      4'd0:    seg_next = 8'hC0;
      4'd1:    seg_next = 8'hF9;
      4'd2:    seg_next = 8'hA4;
      4'd3:    seg_next = 8'hB0;
      4'd4:    seg_next = 8'h99;
      4'd5:    seg_next = 8'h92;
      4'd6:    seg_next = 8'h82;
      4'd7:    seg_next = 8'hF8;
      4'd8:    seg_next = 8'h80;
      4'd9:    seg_next = 8'h90;
      default: seg_next = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg      <= 4'b0000;
      armed_reg     <= 1'b0;
      paused        <= 1'b0;
      sec_ones      <= 4'd0;
      sec_tens      <= 3'd0;
      min_ones      <= 4'd0;
      min_tens      <= 3'd0;
      digit_idx_reg <= 2'd0;
      an            <= 4'b1111;
      seg           <= 8'hFF;
    end else begin
      prev_reg  <= lvl;
      armed_reg <= 1'b1;
      if (tick[3]) paused <= ~paused;
      if (sec_inc) begin
        if (sec_ones == 4'd9) begin
          sec_ones <= 4'd0;
          sec_tens <= (sec_tens == 3'd5) ? 3'd0 : sec_tens + 3'd1;
        end else begin
          sec_ones <= sec_ones + 4'd1;
        end
      end
      if (min_inc) begin
        if (min_ones == 4'd9) begin
          min_ones <= 4'd0;
          min_tens <= (min_tens == 3'd5) ? 3'd0 : min_tens + 3'd1;
        end else begin
          min_ones <= min_ones + 4'd1;
        end
      end
      if (tick[2]) digit_idx_reg <= digit_idx_reg + 2'd1;
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// Scenario bench for stopwatch_display: a reference model pushes expected
// counter and display states to queues, which are popped once the DUT updates.
module tb_stopwatch_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       onehz_clk = 1'b0, twohz_clk = 1'b0, fast_clk = 1'b0, blink_clk = 1'b0;
  logic       pause_btn = 1'b0, adj = 1'b0, sel = 1'b0;
  logic [2:0] min_tens, sec_tens;
  logic [3:0] min_ones, sec_ones;
  logic       paused;
  logic [3:0] an;
  logic [7:0] seg;

  stopwatch_display dut (
    .clk(clk), .rst(rst), .onehz_clk(onehz_clk), .twohz_clk(twohz_clk),
    .fast_clk(fast_clk), .blink_clk(blink_clk), .pause_btn(pause_btn),
    .adj(adj), .sel(sel), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .paused(paused), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int   m_m = 0, m_s = 0, m_d = 0;
  logic m_paused = 1'b0;
  logic [14:0] exp_q[$];
  logic [11:0] disp_q[$];

  function automatic logic [14:0] pack_exp();
    return {3'(m_m / 10), 4'(m_m % 10), 3'(m_s / 10), 4'(m_s % 10), m_paused};
  endfunction

  function automatic logic [7:0] seg_tab(input int v);
    case (v)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [11:0] disp_exp();
    int v;
    logic [3:0] a;
    case (m_d)
      0: begin v = m_s % 10; a = 4'b1110; end
      1: begin v = m_s / 10; a = 4'b1101; end
      2: begin v = m_m % 10; a = 4'b1011; end
      default: begin v = m_m / 10; a = 4'b0111; end
    endcase
    if (adj && blink_clk && (sel ? (m_d < 2) : (m_d >= 2))) a = 4'b1111;
    return {a, seg_tab(v)};
  endfunction

  // One pulse cycle on the chosen divider inputs, then a low cycle; returns at
  // the negedge right after the edge that consumes the tick.
  task automatic step(input logic t1, input logic t2, input logic tb, input logic tf);
    logic old_p;
    @(negedge clk);
    onehz_clk = t1; twohz_clk = t2; pause_btn = tb; fast_clk = tf;
    old_p = m_paused;
    if (tb) m_paused = ~m_paused;
    if (!old_p) begin
      if (!adj && t1) begin
        m_s = m_s + 1;
        if (m_s == 60) begin m_s = 0; m_m = (m_m + 1) % 60; end
      end
      if (adj && t2) begin
        if (sel) m_s = (m_s + 1) % 60;
        else     m_m = (m_m + 1) % 60;
      end
    end
    if (tf) m_d = (m_d + 1) % 4;
    exp_q.push_back(pack_exp());
    @(negedge clk);
    onehz_clk = 1'b0; twohz_clk = 1'b0; pause_btn = 1'b0; fast_clk = 1'b0;
  endtask

  task automatic set_time(input int mm, input int ss);
    logic [14:0] got, e;
    adj = 1'b1;
    for (int f = 0; f < 2; f++) begin
      sel = f[0];
      while ((f == 0) ? (m_m != mm) : (m_s != ss)) begin
        step(1'b0, 1'b1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        got = {min_tens, min_ones, sec_tens, sec_ones, paused};
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL preload: got %h required %h", got, e);
        end else $display("preload %0d%0d:%0d%0d", min_tens, min_ones, sec_tens, sec_ones);
      end
    end
    adj = 1'b0; sel = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] got;
    logic [11:0] dgot, de;
    @(negedge clk);
    rst = 1'b1;
    {onehz_clk, twohz_clk, fast_clk, blink_clk, pause_btn, adj, sel} = 7'h7F;
    repeat (3) @(negedge clk);
    got = {min_tens, min_ones, sec_tens, sec_ones, paused};
    n_checks++;
    if (got !== 15'd0 || an !== 4'b1111 || seg !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_state: got cnt=%h an=%b seg=%h required cnt=0 an=1111 seg=ff", got, an, seg);
    end else $display("reset state an=%b seg=%h", an, seg);
    m_m = 0; m_s = 0; m_d = 0; m_paused = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    got = {min_tens, min_ones, sec_tens, sec_ones, paused};
    dgot = {an, seg};
    de = disp_exp();
    n_checks++;
    if (got !== pack_exp() || dgot !== de) begin
      n_fail++;
      $display("FAIL release_held: got cnt=%h disp=%h required cnt=%h disp=%h", got, dgot, pack_exp(), de);
    end else $display("release held-high cnt=%h disp=%h", got, dgot);
    blink_clk = 1'b0;
    repeat (2) @(negedge clk);
    de = disp_exp();
    n_checks++;
    if ({an, seg} !== de) begin
      n_fail++;
      $display("FAIL release_digit0: got %h required %h", {an, seg}, de);
    end else $display("release digit0 disp=%h", {an, seg});
    {onehz_clk, twohz_clk, fast_clk, blink_clk, pause_btn, adj, sel} = 7'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_count();
    logic [14:0] got, e;
    set_time(0, 58);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) set_time(59, 59);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      got = {min_tens, min_ones, sec_tens, sec_ones, paused};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL count_%0d: got %h required %h", i, got, e);
      end else $display("count %0d%0d:%0d%0d", min_tens, min_ones, sec_tens, sec_ones);
    end
  endtask

  task automatic test_pause();
    logic [14:0] got, e;
    set_time(0, 5);
    for (int i = 0; i < 7; i++) begin
      if (i == 5) step(1'b0, 1'b0, 1'b1, 1'b0);
      else        step(1'b1, 1'b0, (i == 0), 1'b0);
      e = exp_q.pop_front();
      got = {min_tens, min_ones, sec_tens, sec_ones, paused};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL pause_%0d: got %h required %h", i, got, e);
      end else $display("pause %0d%0d:%0d%0d paused=%b", min_tens, min_ones, sec_tens, sec_ones, paused);
    end
  endtask

  task automatic test_adjust();
    logic [14:0] got, e;
    set_time(58, 30);
    for (int i = 0; i < 9; i++) begin
      if (i == 5) set_time(1, 59);
      adj = (i != 7);
      sel = (i >= 5);
      if (i < 3 || i == 5) step(1'b0, 1'b1, 1'b0, 1'b0);
      else if (i < 5)      step(1'b1, 1'b0, 1'b0, 1'b0);
      else                 step(1'b1, 1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front();
      got = {min_tens, min_ones, sec_tens, sec_ones, paused};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL adjust_%0d: got %h required %h", i, got, e);
      end else $display("adjust %0d%0d:%0d%0d", min_tens, min_ones, sec_tens, sec_ones);
    end
    adj = 1'b0; sel = 1'b0;
  endtask

  task automatic test_scan_blink();
    logic [14:0] got, e;
    logic [11:0] de;
    set_time(12, 34);
    repeat (2) @(negedge clk);
    de = disp_exp();
    n_checks++;
    if ({an, seg} !== de) begin
      n_fail++;
      $display("FAIL scan_start: got %h required %h", {an, seg}, de);
    end else $display("scan start an=%b seg=%h", an, seg);
    for (int i = 0; i < 12; i++) begin
      if (i == 4) begin adj = 1'b1; sel = 1'b1; blink_clk = 1'b1; end
      if (i == 8) blink_clk = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b1);
      disp_q.push_back(disp_exp());
      e = exp_q.pop_front();
      got = {min_tens, min_ones, sec_tens, sec_ones, paused};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL scan_hold_%0d: got %h required %h", i, got, e);
      end
      @(negedge clk);
      de = disp_q.pop_front();
      n_checks++;
      if ({an, seg} !== de) begin
        n_fail++;
        $display("FAIL scan_%0d: got %h required %h", i, {an, seg}, de);
      end else $display("scan %0d an=%b seg=%h", i, an, seg);
    end
    adj = 1'b0; sel = 1'b0;
  endtask

  task automatic test_reset_tick();
    logic [14:0] got, e;
    @(negedge clk);
    rst = 1'b1;
    onehz_clk = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_m = 0; m_s = 0; m_d = 0; m_paused = 1'b0;
    repeat (3) @(negedge clk);
    got = {min_tens, min_ones, sec_tens, sec_ones, paused};
    n_checks++;
    if (got !== pack_exp()) begin
      n_fail++;
      $display("FAIL reset_tick: got %h required %h", got, pack_exp());
    end else $display("reset over tick cnt=%h", got);
    onehz_clk = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front();
    got = {min_tens, min_ones, sec_tens, sec_ones, paused};
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL first_tick: got %h required %h", got, e);
    end else $display("first tick cnt=%h", got);
  endtask

  initial begin
    test_reset();
    test_count();
    test_pause();
    test_adjust();
    test_scan_blink();
    test_reset_tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/stopwatch_display.md
# stopwatch_display

Consumer of the divider outputs (`onehz_clk`, `twohz_clk`, `fast_clk`, `blink_clk`). Edge-detects each divided level into single-cycle ticks in the `clk` domain. Keeps a BCD MM:SS stopwatch with pause and per-field adjust. Drives a 4-digit multiplexed active-low seven-segment display.

## Interface

Parameters:
- none; all rates come from the divider inputs.

Ports:
- `clk`  in  1  system clock; the same clock as the divider.
- `rst`  in  1  synchronous, active-high reset.
- `onehz_clk`  in  1  divider level; its rising edge is the count tick.
- `twohz_clk`  in  1  divider level; its rising edge is the adjust tick.
- `fast_clk`  in  1  divider level; its rising edge is the digit-scan tick.
- `blink_clk`  in  1  divider level, used as a level for blanking.
- `pause_btn`  in  1  debounced and synchronised button; its rising edge toggles pause.
- `adj`  in  1  1 = adjust mode.
- `sel`  in  1  field chosen in adjust mode: 0 = minutes, 1 = seconds.
- `min_tens`  out  3  minutes tens digit, 0–5.
- `min_ones`  out  4  minutes ones digit, 0–9.
- `sec_tens`  out  3  seconds tens digit, 0–5.
- `sec_ones`  out  4  seconds ones digit, 0–9.
- `paused`  out  1  pause state.
- `an`  out  4  digit enables, active-low, one-hot or all-high.
- `seg`  out  8  segments {dp,g,f,e,d,c,b,a}, active-low; dp is always 1 (off).

## Operation

Edge detection:
- One `prev_*` register per divider input.
- `tick_x = x & ~prev_x`, combinational.
- Every `prev_*` resets to 0.

Pause:
- `pause_btn` rising edge toggles `paused`.
- All counting decisions in a cycle use the `paused` value registered before that cycle's toggle.

Normal mode (`adj`=0, `paused`=0), on `tick_1hz`:
- `sec_ones` +1, wrapping 9→0 with carry into `sec_tens`.
- `sec_tens` wraps 5→0 with carry into `min_ones`.
- `min_ones` wraps 9→0 with carry into `min_tens`.
- `min_tens` wraps 5→0; 59:59 → 00:00.
- `tick_2hz` is ignored.

Adjust mode (`adj`=1, `paused`=0):
- `tick_1hz` is ignored.
- On `tick_2hz`, the field chosen by `sel` increments modulo 60 (BCD, xx:59→xx:00 or 59:xx→00:xx).
- No carry into the other field; the other field holds.

Paused:
- All counters hold in both modes. Display scan and blink keep running.

Mode changes:
- `adj`/`sel` changes apply from the cycle they are sampled. No counter is cleared.

Display scan:
- 2-bit `digit_idx` advances on `tick_fast`, wrapping 3→0.
- Digit map: 0 = `sec_ones`/`an`=1110, 1 = `sec_tens`/1101, 2 = `min_ones`/1011, 3 = `min_tens`/0111.
- Decoder, active-low {g..a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

Blink:
- Applies when `adj`=1 and `blink_clk`=1.
- If the current digit belongs to the selected field (`sel`=1: digits 0–1; `sel`=0: digits 2–3), `an` = 1111.
- `seg` still carries the decoded value.

Reset values:
- All counters 0 (00:00).
- `paused` = 0.
- `digit_idx` = 0.
- `an` = 1111, `seg` = 11111111.

## Timing

Counter update:
- A tick is seen in cycle N when the input is 1 at edge N and `prev` was 0.
- The counter outputs show the new value after edge N+1.
- Each divider rising edge gives exactly one tick. A level held high gives no further ticks.

Display:
- `an`/`seg` are registered from `digit_idx` and the counters, one cycle behind them.
- Total latency, divider edge to new digit pattern: 2 cycles when that digit is currently scanned.

Pause:
- `paused` toggles at edge N+1 after a `pause_btn` rising edge seen in cycle N.
- A `tick_1hz` in the same cycle N is applied or dropped according to the old `paused` value.

Reset:
- A `rst` asserted mid-count, or while a tick is asserted, wins.
- The next state is the reset state and the tick is lost.
- The first tick after reset release needs a 0→1 transition on the input.

Coincident ticks:
- `tick_1hz` and `tick_2hz` in the same cycle: only the one for the current mode acts.
- `tick_fast` is independent of both.

## Test plan

- **Reset:** hold `rst` 3 cycles with all inputs 1 → `an`=1111, `seg`=FF, counters 00:00, `paused`=0. Release with the inputs held at 1 → no count.
- **Normal count and wrap:** preload 00:58, drive 3 `onehz_clk` pulses → 00:59, 01:00, 01:01, each one cycle after its tick. Preload 59:59, drive one pulse → 00:00.
- **Pause:** drive a `pause_btn` pulse coincident with a 1 Hz tick at 00:05 → 00:06 and `paused`=1. 4 more ticks → still 00:06. Another button edge, then 1 tick → 00:07.
- **Adjust:** `adj`=1, `sel`=0 at 58:30, 3 `twohz_clk` pulses → 59:30, 00:30, 01:30, with seconds unchanged. Drive `onehz_clk` pulses → no change. `sel`=1 at 01:59, one pulse → 01:00.
- **Scan and decode:** counters 12:34, 4 `fast_clk` pulses → (`an`,`seg`) = (1110, 0x99), (1101, 0xB0), (1011, 0xA4), (0111, 0xF9), then wraps to digit 0.
- **Blink:** `adj`=1, `sel`=1, `blink_clk`=1 → `an`=1111 on digits 0–1 and normal on digits 2–3. `blink_clk`=0 → all digits lit.
